// File: rtl/gpio_multiport_pkg.sv
`default_nettype none
// ============================================================================
// Module      : gpio_multiport_pkg
// Description : Shared constants and types for the multi-port GPIO bank:
//               register offsets within a port group, group stride, default
//               global register addresses and the per-port write-strobe
//               bundle.
// Revision    : 1.0 - initial release
// ============================================================================
package gpio_multiport_pkg;

  // Each port occupies a group of four consecutive I/O addresses.
  localparam int unsigned GROUP_STRIDE = 4;

  localparam logic [1:0] OFS_PIN   = 2'd0;
  localparam logic [1:0] OFS_DDR   = 2'd1;
  localparam logic [1:0] OFS_PORT  = 2'd2;
  localparam logic [1:0] OFS_PCMSK = 2'd3;

  localparam logic [5:0] PCICR_ADDR_DEFAULT = 6'h3C;
  localparam logic [5:0] PCIFR_ADDR_DEFAULT = 6'h3D;

  // One write strobe per register of a port group.
  typedef struct packed {
    logic pin;
    logic ddr;
    logic port;
    logic pcmsk;
  } port_wr_t;

endpackage
`default_nettype wire

// File: rtl/gpio_multiport_port.sv
`default_nettype none
// ============================================================================
// Module      : gpio_multiport_port
// Description : One GPIO port slice: DDR/PORT/PCMSK registers, two-stage
//               input synchroniser feeding PIN, previous-sample register,
//               tristate pin drive and masked pin-change output.
//               State updates on the falling clock edge.
// Optional    : GPIO_PIN_TOGGLE_EN - a PIN write toggles PORT (PORT ^= D).
// Ports       : clk, reset (sync, active-high)
//               wr       - per-register write strobes for this group
//               wdata    - bus write data
//               rd_ofs   - register offset selected for readback
//               rd_data  - contents of the register at rd_ofs
//               chg      - a masked pin changed between prev and PIN
//               pins     - external pins (inout)
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_multiport_port
  import gpio_multiport_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  port_wr_t              wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [1:0]            rd_ofs,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  chg,
  inout  wire  [DATA_WIDTH-1:0] pins
);

`ifdef GPIO_PIN_TOGGLE_EN
  localparam bit PIN_TOGGLE = 1'b1;
`else
  localparam bit PIN_TOGGLE = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] ddr_q,   ddr_d;
  logic [DATA_WIDTH-1:0] port_q,  port_d;
  logic [DATA_WIDTH-1:0] pcmsk_q, pcmsk_d;
  logic [DATA_WIDTH-1:0] sync1_q, sync1_d;
  logic [DATA_WIDTH-1:0] pin_q,   pin_d;
  logic [DATA_WIDTH-1:0] prev_q,  prev_d;

  always_comb begin
    ddr_d   = ddr_q;
    port_d  = port_q;
    pcmsk_d = pcmsk_q;
    if (wr.ddr)   ddr_d   = wdata;
    if (wr.port)  port_d  = wdata;
    if (wr.pcmsk) pcmsk_d = wdata;
    // PIN stays read-only; with toggling enabled the write lands on PORT.
    if (PIN_TOGGLE && wr.pin) port_d = port_q ^ wdata;

    // sync1 -> PIN -> prev: PIN is the metastability-safe view of the pins,
    // prev holds the PIN value one edge older for change detection.
    sync1_d = pins;
    pin_d   = sync1_q;
    prev_d  = pin_q;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      ddr_q   <= '0;
      port_q  <= '0;
      pcmsk_q <= '0;
      sync1_q <= '0;
      pin_q   <= '0;
      prev_q  <= '0;
    end else begin
      ddr_q   <= ddr_d;
      port_q  <= port_d;
      pcmsk_q <= pcmsk_d;
      sync1_q <= sync1_d;
      pin_q   <= pin_d;
      prev_q  <= prev_d;
    end
  end

  // Per-bit tristate so input pins float while outputs are driven.
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_drive
    assign pins[i] = ddr_q[i] ? port_q[i] : 1'bz;
  end

  // Mask is applied at compare time, so an edge still in the synchroniser
  // follows whatever PCMSK holds when it reaches PIN.
  assign chg = |((pin_q ^ prev_q) & pcmsk_q);

  always_comb begin
    rd_data = '0;
    case (rd_ofs)
      OFS_PIN:   rd_data = pin_q;
      OFS_DDR:   rd_data = ddr_q;
      OFS_PORT:  rd_data = port_q;
      OFS_PCMSK: rd_data = pcmsk_q;
      default:   rd_data = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/gpio_multiport.sv
`default_nettype none
// ============================================================================
// Module      : gpio_multiport
// Description : Memory-mapped GPIO bank with NUM_PORTS ports of DATA_WIDTH
//               pins. Port k group lives at GPIO_BASE+4k (PIN, DDR, PORT,
//               PCMSK). Global PCICR (enable) and PCIFR (flags, W1C) produce
//               a level irq. All state updates on the falling clock edge.
// Optional    : GPIO_PIN_TOGGLE_EN - PIN writes toggle the port's PORT reg.
// Ports       : clk      - bus clock (negedge active)
//               reset    - synchronous, active-high
//               oe/cs/we - bus output enable, chip select, write enable
//               address  - I/O register address
//               data     - bidirectional data bus, high-Z unless reading
//               pins     - external pins, port k at [k*DATA_WIDTH +: DATA_WIDTH]
//               irq      - |(PCIFR & PCICR)
// Revision    : 1.0 - initial release
// ============================================================================
module gpio_multiport
  import gpio_multiport_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = 8,
  parameter int unsigned           ADDR_WIDTH = 6,
  parameter int unsigned           NUM_PORTS  = 2,
  parameter logic [ADDR_WIDTH-1:0] GPIO_BASE  = '0,
  parameter logic [ADDR_WIDTH-1:0] PCICR_ADDR = ADDR_WIDTH'(PCICR_ADDR_DEFAULT),
  parameter logic [ADDR_WIDTH-1:0] PCIFR_ADDR = ADDR_WIDTH'(PCIFR_ADDR_DEFAULT)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            oe,
  input  logic                            cs,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           address,
  inout  wire  [DATA_WIDTH-1:0]           data,
  inout  wire  [NUM_PORTS*DATA_WIDTH-1:0] pins,
  output logic                            irq
);

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] addr_buf_q, addr_buf_d;
  logic [NUM_PORTS-1:0]  pcicr_q, pcicr_d;
  logic [NUM_PORTS-1:0]  pcifr_q, pcifr_d;
  logic [NUM_PORTS-1:0]  chg;
  logic [NUM_PORTS-1:0]  rd_hit;
  logic [DATA_WIDTH-1:0] port_rd [NUM_PORTS];
  logic [DATA_WIDTH-1:0] rd_mux;

  assign wr_en = cs && we;

  for (genvar k = 0; k < NUM_PORTS; k++) begin : g_port
    localparam logic [ADDR_WIDTH-1:0] GRP_BASE =
      GPIO_BASE + ADDR_WIDTH'(GROUP_STRIDE * k);

    logic [ADDR_WIDTH-1:0] wr_rel;
    logic [ADDR_WIDTH-1:0] rd_rel;
    logic                  wr_in;
    port_wr_t              wr;

    // Offset from the group base; anything >= stride is outside this group.
    assign wr_rel     = address - GRP_BASE;
    assign rd_rel     = addr_buf_q - GRP_BASE;
    assign wr_in      = wr_en && (wr_rel < ADDR_WIDTH'(GROUP_STRIDE));
    assign rd_hit[k]  = (rd_rel < ADDR_WIDTH'(GROUP_STRIDE));

    always_comb begin
      wr.pin   = wr_in && (wr_rel[1:0] == OFS_PIN);
      wr.ddr   = wr_in && (wr_rel[1:0] == OFS_DDR);
      wr.port  = wr_in && (wr_rel[1:0] == OFS_PORT);
      wr.pcmsk = wr_in && (wr_rel[1:0] == OFS_PCMSK);
    end

    gpio_multiport_port #(
      .DATA_WIDTH (DATA_WIDTH)
    ) u_port (
      .clk     (clk),
      .reset   (reset),
      .wr      (wr),
      .wdata   (data),
      .rd_ofs  (rd_rel[1:0]),
      .rd_data (port_rd[k]),
      .chg     (chg[k]),
      .pins    (pins[k*DATA_WIDTH +: DATA_WIDTH])
    );
  end

  always_comb begin
    addr_buf_d = addr_buf_q;
    if (cs && !we) addr_buf_d = address;

    pcicr_d = pcicr_q;
    if (wr_en && (address == PCICR_ADDR)) pcicr_d = data[NUM_PORTS-1:0];

    // Clear first, then OR in new changes so a coincident set wins.
    pcifr_d = pcifr_q;
    if (wr_en && (address == PCIFR_ADDR)) pcifr_d = pcifr_q & ~data[NUM_PORTS-1:0];
    pcifr_d = pcifr_d | chg;
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      addr_buf_q <= '0;
      pcicr_q    <= '0;
      pcifr_q    <= '0;
    end else begin
      addr_buf_q <= addr_buf_d;
      pcicr_q    <= pcicr_d;
      pcifr_q    <= pcifr_d;
    end
  end

  // Read mux keyed on the address captured at the last read edge; the
  // global registers only expose their NUM_PORTS low bits.
  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      if (rd_hit[k]) rd_mux = rd_mux | port_rd[k];
    end
    if (addr_buf_q == PCICR_ADDR) rd_mux[NUM_PORTS-1:0] = pcicr_q;
    if (addr_buf_q == PCIFR_ADDR) rd_mux[NUM_PORTS-1:0] = pcifr_q;
  end

  assign data = (cs && oe && !we) ? rd_mux : {DATA_WIDTH{1'bz}};
  assign irq  = |(pcifr_q & pcicr_q);

endmodule
`default_nettype wire

// File: tb/tb_gpio_multiport.sv
`default_nettype none
// ============================================================================
// Module      : tb_gpio_multiport
// Description : Directed self-checking bench for gpio_multiport (2 ports x 8).
//               Inputs change on posedge, DUT state moves on negedge, outputs
//               are sampled on posedge. Pins are pulled low when undriven.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gpio_multiport;

  localparam int DW = 8;
  localparam int AW = 6;
  localparam int NP = 2;

`ifdef GPIO_PIN_TOGGLE_EN
  localparam logic [DW-1:0] EXP_TOGGLE_PORT = 8'hF0;
`else
  localparam logic [DW-1:0] EXP_TOGGLE_PORT = 8'h0F;
`endif

  logic             clk        = 1'b0;
  logic             reset      = 1'b1;
  logic             oe         = 1'b0;
  logic             cs         = 1'b0;
  logic             we         = 1'b0;
  logic [AW-1:0]    address    = '0;
  logic [DW-1:0]    tb_data    = '0;
  logic             tb_data_oe = 1'b0;
  logic [NP*DW-1:0] tb_pin_val = '0;
  logic [NP*DW-1:0] tb_pin_oe  = '0;

  wire  [DW-1:0]    data;
  wire  [NP*DW-1:0] pins;
  wire              irq;

  int n_vec = 0;
  int n_err = 0;

  assign data = tb_data_oe ? tb_data : {DW{1'bz}};

  for (genvar i = 0; i < NP*DW; i++) begin : g_pin
    assign pins[i] = tb_pin_oe[i] ? tb_pin_val[i] : 1'bz;
    pulldown (pins[i]);
  end

  always #5 clk = ~clk;

  gpio_multiport dut (
    .clk     (clk),
    .reset   (reset),
    .oe      (oe),
    .cs      (cs),
    .we      (we),
    .address (address),
    .data    (data),
    .pins    (pins),
    .irq     (irq)
  );

  // Bus tasks start and end on a posedge; one negedge passes in between.
  task automatic bus_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cs = 1'b1; we = 1'b1; oe = 1'b0; address = a; tb_data = d; tb_data_oe = 1'b1;
    @(posedge clk);
    cs = 1'b0; we = 1'b0; tb_data_oe = 1'b0;
  endtask

  task automatic bus_read(input logic [AW-1:0] a, output logic [DW-1:0] d);
    cs = 1'b1; we = 1'b0; oe = 1'b1; address = a;
    @(posedge clk);
    d = data;
    cs = 1'b0; oe = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic test_reset();
    logic [DW-1:0] rd;
    logic [AW-1:0] addrs [10];
    addrs = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h3C, 6'h3D};
    bus_write(6'h03, 8'hFF);
    bus_write(6'h3C, 8'h03);
    bus_write(6'h01, 8'hFF);
    bus_write(6'h02, 8'hFF);
    bus_write(6'h05, 8'hFF);
    bus_write(6'h06, 8'hFF);
    idle(4);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL reset_pre_irq: got %b expected 1", irq);
    end
    // Reset for one negedge with a write pending in the same cycle.
    reset = 1'b1; cs = 1'b1; we = 1'b1; address = 6'h06; tb_data = 8'h55; tb_data_oe = 1'b1;
    @(posedge clk);
    reset = 1'b0; cs = 1'b0; we = 1'b0; tb_data_oe = 1'b0;
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL reset_irq: got %b expected 0", irq);
    end
    n_vec++;
    if (pins !== 16'h0000) begin
      n_err++; $display("FAIL reset_pins: got %h expected 0000 (released)", pins);
    end
    for (int i = 0; i < 10; i++) begin
      bus_read(addrs[i], rd);
      n_vec++;
      if (rd !== 8'h00) begin
        n_err++; $display("FAIL reset_reg[%h]: got %h expected 00", addrs[i], rd);
      end
    end
  endtask

  task automatic test_output_drive();
    logic [DW-1:0] rd;
    bus_write(6'h01, 8'hF0);
    bus_write(6'h02, 8'hA5);
    n_vec++;
    if (pins[7:0] !== 8'hA0) begin
      n_err++; $display("FAIL drive_pins0: got %h expected a0", pins[7:0]);
    end
    n_vec++;
    if (pins[15:8] !== 8'h00) begin
      n_err++; $display("FAIL drive_pins1: got %h expected 00", pins[15:8]);
    end
    bus_read(6'h00, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL pin0_sync_1edge: got %h expected 00", rd);
    end
    bus_read(6'h00, rd);
    n_vec++;
    if (rd !== 8'hA0) begin
      n_err++; $display("FAIL pin0_sync_2edge: got %h expected a0", rd);
    end
    // Low nibble must be high-Z: bench drive shows through unopposed.
    tb_pin_oe[3:0] = 4'hF; tb_pin_val[3:0] = 4'hA;
    @(posedge clk);
    n_vec++;
    if (pins[7:0] !== 8'hAA) begin
      n_err++; $display("FAIL drive_hiz_nibble: got %h expected aa", pins[7:0]);
    end
    tb_pin_oe[3:0] = 4'h0;
  endtask

  task automatic test_pin_change();
    logic [DW-1:0] rd;
    tb_pin_oe[8] = 1'b1; tb_pin_val[8] = 1'b0;
    bus_write(6'h07, 8'h01);
    bus_write(6'h3C, 8'h02);
    idle(3);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL pc_idle_irq: got %b expected 0", irq);
    end
    tb_pin_val[8] = 1'b1;
    @(posedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL pc_irq_edge_n: got %b expected 0", irq);
    end
    @(posedge clk);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL pc_irq_edge_n1: got %b expected 0", irq);
    end
    @(posedge clk);
    n_vec++;
    if (irq !== 1'b1) begin
      n_err++; $display("FAIL pc_irq_edge_n2: got %b expected 1", irq);
    end
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h02) begin
      n_err++; $display("FAIL pc_flag: got %h expected 02", rd);
    end
    bus_write(6'h3D, 8'h02);
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL pc_clear_irq: got %b expected 0", irq);
    end
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL pc_clear_flag: got %h expected 00", rd);
    end
  endtask

  task automatic test_masking();
    logic [DW-1:0] rd;
    bus_write(6'h01, 8'h00);
    tb_pin_oe[7:0] = 8'hFF; tb_pin_val[7:0] = 8'h00;
    idle(4);
    tb_pin_val[7:0] = 8'hFF;
    idle(4);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL mask_off_flag: got %h expected 00", rd);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL mask_off_irq: got %b expected 0", irq);
    end
    bus_write(6'h3C, 8'h00);
    bus_write(6'h03, 8'hFF);
    tb_pin_val[7:0] = 8'h00;
    idle(4);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL mask_on_flag: got %h expected 01", rd);
    end
    n_vec++;
    if (irq !== 1'b0) begin
      n_err++; $display("FAIL mask_on_irq_gated: got %b expected 0", irq);
    end
    bus_write(6'h3D, 8'h01);
  endtask

  task automatic test_mask_mid_sync();
    logic [DW-1:0] rd;
    // Mask cleared on the sampling edge: compare sees mask 0.
    tb_pin_val[7:0] = 8'hFF;
    bus_write(6'h03, 8'h00);
    idle(4);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL midsync_mask_off: got %h expected 00", rd);
    end
    // Mask set on the sampling edge: compare sees mask FF.
    tb_pin_val[7:0] = 8'h00;
    bus_write(6'h03, 8'hFF);
    idle(4);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h01) begin
      n_err++; $display("FAIL midsync_mask_on: got %h expected 01", rd);
    end
    bus_write(6'h3D, 8'h01);
  endtask

  task automatic test_set_wins();
    logic [DW-1:0] rd;
    tb_pin_val[8] = 1'b0;
    idle(4);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h02) begin
      n_err++; $display("FAIL sw_pre_flag: got %h expected 02", rd);
    end
    tb_pin_val[8] = 1'b1;
    @(posedge clk);
    @(posedge clk);
    bus_write(6'h3D, 8'h02);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h02) begin
      n_err++; $display("FAIL sw_flag_kept: got %h expected 02", rd);
    end
    bus_write(6'h3D, 8'h02);
    bus_read(6'h3D, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL sw_clear_after: got %h expected 00", rd);
    end
  endtask

  task automatic test_unmapped();
    logic [DW-1:0] rd;
    bus_write(6'h20, 8'hFF);
    bus_read(6'h20, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL unmapped_rd: got %h expected 00", rd);
    end
    bus_read(6'h08, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL past_last_group: got %h expected 00", rd);
    end
    bus_write(6'h3C, 8'hFF);
    bus_read(6'h3C, rd);
    n_vec++;
    if (rd !== 8'h03) begin
      n_err++; $display("FAIL pcicr_upper_zero: got %h expected 03", rd);
    end
    bus_write(6'h3C, 8'h00);
  endtask

  task automatic test_pin_toggle();
    logic [DW-1:0] rd;
    bus_write(6'h02, 8'h0F);
    bus_write(6'h00, 8'hFF);
    bus_read(6'h02, rd);
    n_vec++;
    if (rd !== EXP_TOGGLE_PORT) begin
      n_err++; $display("FAIL toggle_port0: got %h expected %h", rd, EXP_TOGGLE_PORT);
    end
    bus_read(6'h00, rd);
    n_vec++;
    if (rd !== 8'h00) begin
      n_err++; $display("FAIL toggle_pin_ro: got %h expected 00", rd);
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    reset = 1'b0;
    test_reset();
    test_output_drive();
    test_pin_change();
    test_masking();
    test_mask_mid_sync();
    test_set_wins();
    test_unmapped();
    test_pin_toggle();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/gpio_multiport.md
Name: gpio_multiport

Overview:
- Parametrised successor to the two-port I/O register file: memory-mapped GPIO bank with NUM_PORTS ports of DATA_WIDTH pins each, on the CPU I/O bus.
- Each port provides:
  - DDR, PORT and PCMSK registers.
  - A read-only, 2-flop-synchronised PIN register.
  - Pin-change detection.
- Global interrupt enable/flag registers produce one irq line to the CPU interrupt controller.

Parameters:
- DATA_WIDTH, 8, pins per port and bus width.
- ADDR_WIDTH, 6, I/O address width (64 locations).
- NUM_PORTS, 2, number of ports; legal range 1..DATA_WIDTH; 4*NUM_PORTS+GPIO_BASE must be less than PCICR_ADDR.
- GPIO_BASE, 6'h00, address of port 0 register group.
- PCICR_ADDR, 6'h3C, pin-change interrupt enable register.
- PCIFR_ADDR, 6'h3D, pin-change interrupt flag register.

Ports:
- clk  input  1  bus clock; all state updates on negedge clk.
- reset  input  1  reset, synchronous, active-high.
- oe  input  1  output enable for reads.
- cs  input  1  chip select.
- we  input  1  write enable.
- address  input  ADDR_WIDTH  I/O register address.
- data  inout  DATA_WIDTH  bidirectional data bus; high-Z when not reading.
- pins  inout  NUM_PORTS*DATA_WIDTH  external pins; port k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- irq  output  1  level interrupt request.

Behaviour:
- Address map: port k group at GPIO_BASE+4k.
  - +0: PINk, read-only.
  - +1: DDRk.
  - +2: PORTk.
  - +3: PCMSKk.
  - PCICR and PCIFR use bits [NUM_PORTS-1:0]; upper bits read 0.
  - Unmapped addresses read 0; writes to them are ignored.
- Reset: at a negedge with reset=1, all of the following clear to 0:
  - DDR, PORT, PCMSK, PCICR, PCIFR.
  - Synchroniser stages and previous-sample registers.
  - addr_buf.
  - Consequences: all pins high-Z, irq=0. Reset mid-transaction discards any write in that cycle.
- Pin drive: pins bit i of port k = DDRk[i] ? PORTk[i] : 1'bz. Combinational from registers, so a new output value appears right after the write edge.
- Bus write: at negedge with cs&&we, data is written to the addressed register.
  - PIN writes are ignored unless GPIO_PIN_TOGGLE_EN is defined.
  - A PCIFR write is write-1-to-clear: PCIFR &= ~data.
- Bus read:
  - At negedge with cs&&!we, addr_buf <= address.
  - data = (cs&&oe&&!we) ? reg[addr_buf] : 'z. Combinational, so read data is valid from the negedge after the address is presented.
- Input sync:
  - negedge n: s1 <= pins.
  - negedge n+1: PIN <= s1.
  - negedge n+2: prev <= PIN.
- Change detect:
  - chg_k = |((PINk ^ prevk) & PCMSKk).
  - At each negedge, PCIFR[k] <= PCIFR[k] | chg_k, with the W1C write applied first; if set and clear hit the same edge, set wins.
  - Flags are set regardless of PCICR.
  - Timing: a pin edge sampled at negedge n sets the flag at negedge n+2; irq rises in the same cycle.
- irq = |(PCIFR & PCICR); combinational from registers, no extra latency.
- Output readback: a pin driven as output reads back through PIN after 2 negedges, with the normal sync delay.
- Mask transitions: pins with PCMSK=0 never set flags; an edge that is mid-sync when PCMSK changes follows the PCMSK value at the compare edge.

Optional Feature:
- GPIO_PIN_TOGGLE_EN defined: a write to PINk with data D toggles PORTk: PORTk <= PORTk ^ D. PIN itself stays read-only and is still refreshed from the synchroniser.
- GPIO_PIN_TOGGLE_EN undefined: PIN writes have no effect.

Decomposition:
- Shared defines/package holds:
  - Register offsets OFS_PIN=0, OFS_DDR=1, OFS_PORT=2, OFS_PCMSK=3, and group stride 4.
  - Default PCICR/PCIFR addresses.
- Natural sub-module gpio_port, instantiated NUM_PORTS times via generate. It contains:
  - DDR/PORT/PCMSK registers, synchroniser, prev register, tristate drive, chg output.
  - Write-strobe inputs and a read-data output.
- Top level holds address decode, addr_buf, PCICR/PCIFR, the read mux and irq.

Test Plan:
- Reset: with reset=1 for one negedge after random writes, every register reads 0x00, pins are all 'z and irq=0.
- Output drive: write DDR0=0xF0 then PORT0=0xA5 -> pins[7:0]=1010_zzzz; PIN0 reads 0xAz resolved via pull (bench pulls low) = 0xA0 two negedges later.
- Pin-change interrupt:
  - Setup: PCMSK1=0x01, PCICR=0x02; drive pins[8] 0->1 before negedge n.
  - Response: PCIFR=0x02 and irq=1 at negedge n+2.
  - Clear: writing PCIFR=0x02 clears the flag and drops irq.
- Masking: with PCMSK0=0x00, toggle all port-0 pins -> PCIFR stays 0x00, irq=0. The same toggle with PCICR=0 but PCMSK0=0xFF sets PCIFR[0] with irq=0.
- Set-wins: a W1C write to PCIFR on the same negedge a new masked change is detected -> PCIFR[k] remains 1.
- Toggle feature (macro defined): with PORT0=0x0F, write PIN0=0xFF -> PORT0 reads 0xF0. Macro undefined: PORT0 stays 0x0F.
